// File: rtl/exception_ctrl_pkg.sv
// exception_ctrl_pkg -- shared constants for the exception controller.
//   Event codes handed to CP0 (0 = no event), the fixed handler vector and
//   the controller state encoding.
//   Optional feature macro: EXC_CTRL_TRAP_EN (enables trap code 0xd).
package exception_ctrl_pkg;

   localparam logic [3:0]  EXC_NONE    = 4'h0;
   localparam logic [3:0]  EXC_INT     = 4'h1;
   localparam logic [3:0]  EXC_SYSCALL = 4'h8;
   localparam logic [3:0]  EXC_RI      = 4'ha;
   localparam logic [3:0]  EXC_TRAP    = 4'hd;
   localparam logic [3:0]  EXC_ERET    = 4'he;

   localparam logic [31:0] HANDLER_VEC = 32'h0000_0020;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FLUSH    = 2'd1,
      S_WAIT     = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc -- combinational event priority encoder.
//   Ports: int_req, ri, syscall, trap, eret (event flags, 1 bit each)
//          code (4-bit event code, EXC_NONE when no flag is set).
//   Priority: interrupt > RI > syscall > trap > eret.
//   Macro EXC_CTRL_TRAP_EN: when undefined the trap flag is ignored and
//   code 0xd is never produced.
module exc_prio_enc
   import exception_ctrl_pkg::*;
(
   input  logic       int_req,
   input  logic       ri,
   input  logic       syscall,
   input  logic       trap,
   input  logic       eret,
   output logic [3:0] code
);

   logic trap_req;

`ifdef EXC_CTRL_TRAP_EN
   assign trap_req = trap;
`else
   assign trap_req = 1'b0;
`endif

   always_comb begin
      code = EXC_NONE;
      if (int_req)       code = EXC_INT;
      else if (ri)       code = EXC_RI;
      else if (syscall)  code = EXC_SYSCALL;
      else if (trap_req) code = EXC_TRAP;
      else if (eret)     code = EXC_ERET;
   end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl -- sequences exceptions/eret taken in the memory stage.
//   IDLE -> FLUSH (one cycle, code/PC to CP0) -> WAIT (pick target)
//   -> REDIRECT (hold until fetch accepts) -> IDLE.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     mem_valid_i, mem_pc_i    memory-stage instruction valid / PC
//     mem_syscall_i, mem_ri_i, mem_trap_i, mem_eret_i   event flags
//     status_i, cause_i, epc_i current CP0 Status / Cause / EPC
//     redirect_ready_i         fetch accepts redirect
//     execode_o, exc_pc_o      event code and PC to CP0 (valid in FLUSH)
//     flush_o                  flush IF..MEM
//     redirect_valid_o, redirect_pc_o   redirect request to fetch
//     busy_o                   controller not idle, pipeline holds
//   Macro EXC_CTRL_TRAP_EN: enables trap events (code 0xd).
module exception_ctrl
   import exception_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_syscall_i,
   input  logic        mem_ri_i,
   input  logic        mem_trap_i,
   input  logic        mem_eret_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        redirect_ready_i,
   output logic [3:0]  execode_o,
   output logic [31:0] exc_pc_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic        busy_o
);

   state_t      state, state_nx;
   logic [3:0]  code_q;
   logic [31:0] pc_q;
   logic [31:0] target_q;
   logic [3:0]  enc_code;
   logic        int_req;
   logic        accept;

   // IE set, EXL clear, and some unmasked pending line.
   assign int_req = status_i[0] & ~status_i[1] & (|(status_i[15:8] & cause_i[15:8]));

   exc_prio_enc u_prio (
      .int_req (int_req),
      .ri      (mem_ri_i),
      .syscall (mem_syscall_i),
      .trap    (mem_trap_i),
      .eret    (mem_eret_i),
      .code    (enc_code)
   );

   // A pending interrupt is only taken against a valid memory-stage slot.
   assign accept = (state == S_IDLE) && mem_valid_i && (enc_code != EXC_NONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         code_q   <= EXC_NONE;
         pc_q     <= '0;
         target_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            code_q <= enc_code;
            pc_q   <= mem_pc_i;
         end
         if (state == S_WAIT)
            target_q <= (code_q == EXC_ERET) ? epc_i : HANDLER_VEC;
      end
   end

   always_comb begin
      state_nx         = state;
      execode_o        = EXC_NONE;
      exc_pc_o         = '0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      busy_o           = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nx = S_FLUSH;
         end
         S_FLUSH: begin
            flush_o   = 1'b1;
            execode_o = code_q;
            exc_pc_o  = pc_q;
            busy_o    = 1'b1;
            state_nx  = S_WAIT;
         end
         S_WAIT: begin
            busy_o   = 1'b1;
            state_nx = S_REDIRECT;
         end
         S_REDIRECT: begin
            busy_o           = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = target_q;
            if (redirect_ready_i) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // Outputs read as zero during the reset cycle itself, even mid-sequence.
      if (rst) begin
         execode_o        = EXC_NONE;
         exc_pc_o         = '0;
         flush_o          = 1'b0;
         redirect_valid_o = 1'b0;
         redirect_pc_o    = '0;
         busy_o           = 1'b0;
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl -- directed self-checking bench for exception_ctrl.
module tb_exception_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic        mem_syscall_i, mem_ri_i, mem_trap_i, mem_eret_i;
   logic [31:0] status_i, cause_i, epc_i;
   logic        redirect_ready_i;
   logic [3:0]  execode_o;
   logic [31:0] exc_pc_o;
   logic        flush_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        busy_o;

   int checks   = 0;
   int failures = 0;

   exception_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .mem_valid_i      (mem_valid_i),
      .mem_pc_i         (mem_pc_i),
      .mem_syscall_i    (mem_syscall_i),
      .mem_ri_i         (mem_ri_i),
      .mem_trap_i       (mem_trap_i),
      .mem_eret_i       (mem_eret_i),
      .status_i         (status_i),
      .cause_i          (cause_i),
      .epc_i            (epc_i),
      .redirect_ready_i (redirect_ready_i),
      .execode_o        (execode_o),
      .exc_pc_o         (exc_pc_o),
      .flush_o          (flush_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .busy_o           (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one clock, then settle before sampling/driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_ev();
      mem_valid_i   = 1'b0;
      mem_syscall_i = 1'b0;
      mem_ri_i      = 1'b0;
      mem_trap_i    = 1'b0;
      mem_eret_i    = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".busy"},  {31'd0, busy_o}, 32'd0);
      chk({tag, ".flush"}, {31'd0, flush_o}, 32'd0);
      chk({tag, ".code"},  {28'd0, execode_o}, 32'd0);
      chk({tag, ".rv"},    {31'd0, redirect_valid_o}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      clr_ev();
      mem_pc_i = '0; status_i = '0; cause_i = '0; epc_i = '0;
      redirect_ready_i = 1'b1;
      #1;
      step(); step();
      chk_idle("reset");
      chk("reset.exc_pc", exc_pc_o, 32'd0);
      chk("reset.rpc", redirect_pc_o, 32'd0);
      rst = 1'b0;
      step();

      // RI at PC 0x1000 -> handler vector
      mem_valid_i = 1'b1; mem_ri_i = 1'b1; mem_pc_i = 32'h0000_1000;
      step(); clr_ev(); mem_pc_i = 32'hdead_beef;
      chk("ri.flush", {31'd0, flush_o}, 32'd1);
      chk("ri.code", {28'd0, execode_o}, 32'h0000_000a);
      chk("ri.exc_pc", exc_pc_o, 32'h0000_1000);
      chk("ri.busy", {31'd0, busy_o}, 32'd1);
      step();
      chk("ri.wait.flush", {31'd0, flush_o}, 32'd0);
      chk("ri.wait.code", {28'd0, execode_o}, 32'd0);
      chk("ri.wait.exc_pc", exc_pc_o, 32'd0);
      chk("ri.wait.busy", {31'd0, busy_o}, 32'd1);
      chk("ri.wait.rv", {31'd0, redirect_valid_o}, 32'd0);
      step();
      chk("ri.redir.rv", {31'd0, redirect_valid_o}, 32'd1);
      chk("ri.redir.pc", redirect_pc_o, 32'h0000_0020);
      step();
      chk_idle("ri.done");

      // interrupt beats simultaneous syscall
      status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
      mem_valid_i = 1'b1; mem_syscall_i = 1'b1; mem_pc_i = 32'h0000_1100;
      step(); clr_ev(); status_i = '0; cause_i = '0;
      chk("int.code", {28'd0, execode_o}, 32'h0000_0001);
      chk("int.exc_pc", exc_pc_o, 32'h0000_1100);
      step(); step();
      chk("int.redir.pc", redirect_pc_o, 32'h0000_0020);
      step();
      chk_idle("int.done");

      // eret -> EPC target
      epc_i = 32'h0000_2004;
      mem_valid_i = 1'b1; mem_eret_i = 1'b1; mem_pc_i = 32'h0000_1200;
      step(); clr_ev();
      chk("eret.code", {28'd0, execode_o}, 32'h0000_000e);
      step(); step();
      chk("eret.redir.rv", {31'd0, redirect_valid_o}, 32'd1);
      chk("eret.redir.pc", redirect_pc_o, 32'h0000_2004);
      step();
      chk_idle("eret.done");

      // EXL set: interrupt masked, syscall still runs the full sequence
      status_i = 32'h0000_0403; cause_i = 32'h0000_0400;
      mem_valid_i = 1'b1; mem_syscall_i = 1'b1; mem_pc_i = 32'h0000_1300;
      step(); clr_ev(); status_i = '0; cause_i = '0;
      chk("exl.code", {28'd0, execode_o}, 32'h0000_0008);
      step(); step();
      chk("exl.redir.pc", redirect_pc_o, 32'h0000_0020);
      step();
      chk_idle("exl.done");

      // redirect held off for 5 cycles; a second event in the hold is ignored
      redirect_ready_i = 1'b0;
      mem_valid_i = 1'b1; mem_syscall_i = 1'b1; mem_pc_i = 32'h0000_1400;
      step(); clr_ev();
      chk("hold.code", {28'd0, execode_o}, 32'h0000_0008);
      step(); step();
      mem_valid_i = 1'b1; mem_ri_i = 1'b1; mem_pc_i = 32'h0000_3000;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold.rv%0d", i), {31'd0, redirect_valid_o}, 32'd1);
         chk($sformatf("hold.pc%0d", i), redirect_pc_o, 32'h0000_0020);
         chk($sformatf("hold.flush%0d", i), {31'd0, flush_o}, 32'd0);
         if (i < 4) step();
      end
      // fifth hold cycle ends; ready rises for the sixth
      step(); clr_ev(); redirect_ready_i = 1'b1;
      chk("hold.last.rv", {31'd0, redirect_valid_o}, 32'd1);
      chk("hold.last.pc", redirect_pc_o, 32'h0000_0020);
      step();
      chk_idle("hold.done");
      step();
      chk_idle("hold.done2");

      // reset asserted in WAIT
      mem_valid_i = 1'b1; mem_ri_i = 1'b1; mem_pc_i = 32'h0000_1500;
      step(); clr_ev();
      step();
      chk("rstw.busy", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("rstw.after");
      chk("rstw.exc_pc", exc_pc_o, 32'd0);
      chk("rstw.rpc", redirect_pc_o, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rstw.norv%0d", i), {31'd0, redirect_valid_o}, 32'd0);
         chk($sformatf("rstw.nobusy%0d", i), {31'd0, busy_o}, 32'd0);
      end

      // mem_valid_i low: pending interrupt and RI both ignored
      status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
      mem_ri_i = 1'b1; mem_pc_i = 32'h0000_1600;
      step();
      chk_idle("novalid");
      step();
      chk_idle("novalid2");
      clr_ev(); status_i = '0; cause_i = '0;

      // trap: only taken when the feature is built in
      mem_valid_i = 1'b1; mem_trap_i = 1'b1; mem_pc_i = 32'h0000_1700;
      step(); clr_ev();
`ifdef EXC_CTRL_TRAP_EN
      chk("trap.code", {28'd0, execode_o}, 32'h0000_000d);
      chk("trap.flush", {31'd0, flush_o}, 32'd1);
      step(); step(); step();
`else
      chk_idle("trap.off");
      step();
      chk_idle("trap.off2");
`endif
      chk_idle("trap.end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
